// File: rtl/usb_fs_out_txn_ctrl_if.sv
// Decoder, endpoint-buffer and handshake signals of usb_fs_out_txn_ctrl.
// USB_OUT_TXN_CTRL_STALL_EN adds the per-endpoint ep_stall inputs.
interface usb_fs_out_txn_ctrl_if #(
  parameter int NUM_OUT_EP = 2
);
  logic [6:0]            dev_addr;
  logic                  rx_pkt_start;
  logic                  rx_pkt_end;
  logic [3:0]            rx_pid;
  logic [6:0]            rx_addr;
  logic [3:0]            rx_endp;
  logic [10:0]           rx_frame_num;
  logic                  rx_data_put;
  logic [7:0]            rx_data;
  logic                  rx_valid_pkt;
  logic [NUM_OUT_EP-1:0] ep_ready;
  logic [NUM_OUT_EP-1:0] ep_toggle_clr;
  logic [3:0]            ep_num;
  logic                  ep_data_put;
  logic [7:0]            ep_data;
  logic                  ep_commit;
  logic                  ep_rollback;
  logic                  ep_setup;
  logic                  hs_valid;
  logic [3:0]            hs_pid;
  logic                  hs_ready;
  logic                  sof;
  logic [10:0]           frame_num;
`ifdef USB_OUT_TXN_CTRL_STALL_EN
  logic [NUM_OUT_EP-1:0] ep_stall;

  modport slave (
    input  dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_frame_num,
           rx_data_put, rx_data, rx_valid_pkt, ep_ready, ep_toggle_clr, hs_ready, ep_stall,
    output ep_num, ep_data_put, ep_data, ep_commit, ep_rollback, ep_setup,
           hs_valid, hs_pid, sof, frame_num
  );
  modport master (
    output dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_frame_num,
           rx_data_put, rx_data, rx_valid_pkt, ep_ready, ep_toggle_clr, hs_ready, ep_stall,
    input  ep_num, ep_data_put, ep_data, ep_commit, ep_rollback, ep_setup,
           hs_valid, hs_pid, sof, frame_num
  );
`else
  modport slave (
    input  dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_frame_num,
           rx_data_put, rx_data, rx_valid_pkt, ep_ready, ep_toggle_clr, hs_ready,
    output ep_num, ep_data_put, ep_data, ep_commit, ep_rollback, ep_setup,
           hs_valid, hs_pid, sof, frame_num
  );
  modport master (
    output dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_frame_num,
           rx_data_put, rx_data, rx_valid_pkt, ep_ready, ep_toggle_clr, hs_ready,
    input  ep_num, ep_data_put, ep_data, ep_commit, ep_rollback, ep_setup,
           hs_valid, hs_pid, sof, frame_num
  );
`endif
endinterface

// File: rtl/usb_fs_out_txn_ctrl.sv
// Full-speed USB OUT/SETUP transaction sequencer: token match, CRC16 strip, toggle tracking, handshake.
// Optional USB_OUT_TXN_CTRL_STALL_EN: per-endpoint STALL response via bus.ep_stall.
//
// state     | meaning
// IDLE      | waiting for a token addressed to us, or SOF
// WAIT_DATA | token accepted, waiting for the data packet (bounded by TIMEOUT_CYC)
// DATA      | streaming payload through the 2-byte CRC holding pipe
// HS        | holding the handshake request until the tx side accepts it
module usb_fs_out_txn_ctrl #(
  parameter int NUM_OUT_EP  = 2,
  parameter int MAX_PKT     = 64,
  parameter int TIMEOUT_CYC = 80
) (
  input logic                  clk_48mhz,
  input logic                  reset_n,
  usb_fs_out_txn_ctrl_if.slave bus
);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam int CW  = $clog2(MAX_PKT + 3);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int EPW = (NUM_OUT_EP > 1) ? $clog2(NUM_OUT_EP) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, DATA, HS} state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         byte_cnt;
  logic [1:0]            pipe_cnt;
  logic [7:0]            pipe0, pipe1;
  logic                  is_setup, rdy_q;
  logic [NUM_OUT_EP-1:0] toggle;
  logic [3:0]            ep_num_q, hs_pid_q;
  logic                  commit_q, rollback_q, setup_q, hs_valid_q, sof_q;
  logic [10:0]           frame_q;

  logic [EPW-1:0] ep_idx;
  logic           tok_hit, tog_match, pid_is_data, pipe_full, put_ok, stall_hit;
  logic           end_commit, end_rollback, end_hs, tog_wr, tog_val;
  logic [3:0]     end_pid;

  assign ep_idx      = ep_num_q[EPW-1:0];
  assign tok_hit     = bus.rx_pkt_end && bus.rx_valid_pkt &&
                       (bus.rx_pid == PID_OUT || bus.rx_pid == PID_SETUP) &&
                       bus.rx_addr == bus.dev_addr && {28'd0, bus.rx_endp} < 32'(NUM_OUT_EP);
  assign pid_is_data = bus.rx_pid == PID_DATA0 || bus.rx_pid == PID_DATA1;
  assign tog_match   = (bus.rx_pid == PID_DATA1) == toggle[ep_idx];
  assign pipe_full   = pipe_cnt == 2'd2;
  assign put_ok      = is_setup ? (bus.rx_pid == PID_DATA0) : (rdy_q && tog_match);
`ifdef USB_OUT_TXN_CTRL_STALL_EN
  assign stall_hit   = bus.ep_stall[ep_idx];
`else
  assign stall_hit   = 1'b0;
`endif

  // The oldest held byte leaves only when a newer one arrives, so the final two (CRC16) stay behind.
  assign bus.ep_data_put = state == DATA && bus.rx_data_put && pipe_full &&
                           byte_cnt < CW'(MAX_PKT) && put_ok;
  assign bus.ep_data     = pipe0;
  assign bus.ep_num      = ep_num_q;
  assign bus.ep_commit   = commit_q;
  assign bus.ep_rollback = rollback_q;
  assign bus.ep_setup    = setup_q;
  assign bus.hs_valid    = hs_valid_q;
  assign bus.hs_pid      = hs_pid_q;
  assign bus.sof         = sof_q;
  assign bus.frame_num   = frame_q;

  always_comb begin
    end_commit   = 1'b0;
    end_rollback = 1'b0;
    end_hs       = 1'b0;
    end_pid      = PID_ACK;
    tog_wr       = 1'b0;
    tog_val      = 1'b0;
    if (state == DATA && bus.rx_pkt_end) begin
      if (!bus.rx_valid_pkt || !pid_is_data || byte_cnt > CW'(MAX_PKT) ||
          (is_setup && bus.rx_pid != PID_DATA0)) begin
        end_rollback = 1'b1;
      end else if (is_setup) begin
        end_commit = 1'b1;
        end_hs     = 1'b1;
        tog_wr     = 1'b1;
        tog_val    = 1'b1;
      end else if (stall_hit) begin
        end_rollback = 1'b1;
        end_hs       = 1'b1;
        end_pid      = PID_STALL;
      end else if (!rdy_q) begin
        end_rollback = 1'b1;
        end_hs       = 1'b1;
        end_pid      = PID_NAK;
      end else if (!tog_match) begin
        end_rollback = 1'b1;
        end_hs       = 1'b1;
      end else begin
        end_commit = 1'b1;
        end_hs     = 1'b1;
        tog_wr     = 1'b1;
        tog_val    = ~toggle[ep_idx];
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      toggle <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_EP; i++) begin
        if (bus.ep_toggle_clr[i])
          toggle[i] <= 1'b0;
        else if (tog_wr && ep_num_q == 4'(i))
          toggle[i] <= tog_val;
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      byte_cnt   <= '0;
      pipe_cnt   <= '0;
      pipe0      <= '0;
      pipe1      <= '0;
      is_setup   <= 1'b0;
      rdy_q      <= 1'b0;
      ep_num_q   <= '0;
      hs_pid_q   <= '0;
      commit_q   <= 1'b0;
      rollback_q <= 1'b0;
      setup_q    <= 1'b0;
      hs_valid_q <= 1'b0;
      sof_q      <= 1'b0;
      frame_q    <= '0;
    end else begin
      sof_q      <= 1'b0;
      commit_q   <= 1'b0;
      rollback_q <= 1'b0;
      setup_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_pkt_end && bus.rx_valid_pkt && bus.rx_pid == PID_SOF) begin
            sof_q   <= 1'b1;
            frame_q <= bus.rx_frame_num;
          end
          if (tok_hit) begin
            ep_num_q <= bus.rx_endp;
            is_setup <= bus.rx_pid == PID_SETUP;
            timer    <= '0;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.rx_pkt_start) begin
            rdy_q    <= bus.ep_ready[ep_idx];
            byte_cnt <= '0;
            pipe_cnt <= '0;
            state    <= DATA;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bus.rx_pkt_end) begin
            commit_q   <= end_commit;
            rollback_q <= end_rollback;
            setup_q    <= end_commit && is_setup;
            if (end_hs) begin
              hs_valid_q <= 1'b1;
              hs_pid_q   <= end_pid;
              state      <= HS;
            end else begin
              state <= IDLE;
            end
          end else if (bus.rx_data_put) begin
            if (pipe_full) begin
              pipe0 <= pipe1;
              pipe1 <= bus.rx_data;
              if (byte_cnt != '1)
                byte_cnt <= byte_cnt + 1'b1;
            end else begin
              pipe_cnt <= pipe_cnt + 1'b1;
              if (pipe_cnt == 2'd0)
                pipe0 <= bus.rx_data;
              else
                pipe1 <= bus.rx_data;
            end
          end
        end
        HS: begin
          if (bus.hs_ready) begin
            hs_valid_q <= 1'b0;
            hs_pid_q   <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
